// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped data cache.
// Optional statistics counters are enabled by defining DATA_CACHE_STATS_EN.
package data_cache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 8;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    MEM_READ,
    UPDATE
  } state_t;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side bus of the data cache. The master modport is the
// environment (CPU plus block memory); the slave modport is the cache itself.
interface data_cache_if;
  import data_cache_pkg::*;

  logic                                 read;
  logic                                 write;
  logic [TAG_W+INDEX_W+OFFSET_W-1:0]    address;
  logic [7:0]                           writedata;
  logic [7:0]                           readdata;
  logic                                 busywait;

  logic                                 mem_read;
  logic                                 mem_write;
  logic [TAG_W+INDEX_W-1:0]             mem_address;
  logic [BLOCK_W-1:0]                   mem_writedata;
  logic [BLOCK_W-1:0]                   mem_readdata;
  logic                                 mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/data_cache_ctrl.sv
// Miss-handling FSM: sequences write-back of a dirty victim, block fetch and
// line update. Memory strobes are registered so they never glitch or overlap.
module data_cache_ctrl
  import data_cache_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req,
  input  logic   hit,
  input  logic   victim_dirty,
  input  logic   mem_busywait,
  output state_t state,
  output logic   mem_read,
  output logic   mem_write,
  output logic   busywait
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (victim_dirty) begin
              state     <= WRITE_BACK;
              mem_write <= 1'b1;
            end else begin
              state    <= MEM_READ;
              mem_read <= 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          if (!mem_busywait) begin
            state     <= MEM_READ;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busywait = (req && !hit) || (state != IDLE);

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 lines of 4 bytes.
// Define DATA_CACHE_STATS_EN to add 16-bit wrapping hit_count/miss_count outputs.
module data_cache
  import data_cache_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  data_cache_if.slave bus
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [BLOCK_W-1:0]  data_mem [LINES];

  state_t              state;
  logic                req, hit, idle, fill, rd_hit, wr_hit;
  logic [7:0]          sel_byte;
  logic [7:0]          readdata_q;

  // The CPU holds the request until busywait falls, so the address is used live.
  assign {addr_tag, idx, off} = bus.address;

  assign req      = bus.read || bus.write;
  assign hit      = valid[idx] && (tag_mem[idx] == addr_tag);
  assign idle     = (state == IDLE);
  assign fill     = (state == UPDATE);
  assign wr_hit   = idle && bus.write && hit;
  assign rd_hit   = idle && bus.read && !bus.write && hit;
  assign sel_byte = get_byte(data_mem[idx], off);

  data_cache_ctrl u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .hit          (hit),
    .victim_dirty (valid[idx] && dirty[idx]),
    .mem_busywait (bus.mem_busywait),
    .state        (state),
    .mem_read     (bus.mem_read),
    .mem_write    (bus.mem_write),
    .busywait     (bus.busywait)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; valid=0 makes their contents
  // irrelevant, and leaving them unreset lets them map onto plain RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill) begin
        tag_mem[idx]  <= addr_tag;
        data_mem[idx] <= bus.mem_readdata;
      end else if (wr_hit) begin
        data_mem[idx][{off, 3'b000} +: 8] <= bus.writedata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       readdata_q <= 8'h00;
    else if (rd_hit) readdata_q <= sel_byte;
  end

  // A read hit is visible in the same cycle; otherwise the last value is held.
  assign bus.readdata      = rd_hit ? sel_byte : readdata_q;
  assign bus.mem_address   = (state == WRITE_BACK) ? {tag_mem[idx], idx} : {addr_tag, idx};
  assign bus.mem_writedata = data_mem[idx];

`ifdef DATA_CACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (idle && req) begin
      if (hit) hit_count  <= hit_count + 16'h0001;
      else     miss_count <= miss_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector tables for hit/miss accesses plus
// hand-written sequences for first fill, dirty eviction and reset mid-miss.
module tb_data_cache;

  localparam int LAT    = 2;   // memory busy cycles before completion
  localparam int BUDGET = 50;

  logic clock;
  logic reset;
  data_cache_if bus ();

`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  data_cache dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- block memory model ----------------
  logic [31:0] mem [64];
  int          cnt, ev, wb_ev, rd_ev, traffic;
  logic [5:0]  wb_addr, rd_addr;
  logic [31:0] wb_data;
  logic        overlap;

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt != LAT);

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{i[7:0]}};
    mem[0]  = 32'h44332211;
    mem[1]  = 32'h88776655;
    mem[9]  = 32'hDDCCBBAA;
    mem[16] = 32'hC3C2C1C0;
    cnt = 0; ev = 0; wb_ev = -1; rd_ev = -1; traffic = 0;
    wb_addr = '0; rd_addr = '0; wb_data = '0; overlap = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(posedge clock);
      if (bus.mem_read && bus.mem_write) overlap <= 1'b1;
      if (bus.mem_read || bus.mem_write) begin
        traffic <= traffic + 1;
        if (cnt == LAT) begin
          cnt <= 0;
          ev  <= ev + 1;
          if (bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_writedata;
            wb_addr <= bus.mem_address;
            wb_data <= bus.mem_writedata;
            wb_ev   <= ev;
          end else begin
            rd_addr <= bus.mem_address;
            rd_ev   <= ev;
          end
        end else begin
          cnt <= cnt + 1;
          if (bus.mem_read && cnt == LAT - 1) bus.mem_readdata <= mem[bus.mem_address];
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  // ---------------- CPU access helpers ----------------
  // Entered 1 time unit after a rising edge; returns at the same phase.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rdata, output int stall);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    stall = 0;
    #4;
    while (bus.busywait && stall < BUDGET) begin
      stall++;
      @(posedge clock); #5;
    end
    if (bus.busywait) check($sformatf("access_timeout_%0h", a), {31'b0, bus.busywait}, 32'h0);
    rdata = bus.readdata;
    @(posedge clock); #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] exp_rd;
    int         exp_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic run_vecs(input int lo, input int hi);
    logic [7:0] rdata;
    int stall;
    for (int i = lo; i <= hi; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, stall);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      if (vecs[i].chk) check($sformatf("vec%0d_readdata", i), {24'b0, rdata}, {24'b0, vecs[i].exp_rd});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rdata;
    int stall, tr0;

    //            rd    wr    addr   wdata  chk   exp    stall
    vecs[0]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h22, 0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 0};   // idle: readdata held
    vecs[2]  = '{1'b0, 1'b1, 8'h05, 8'hAB, 1'b0, 8'h00, 5};   // clean write miss
    vecs[3]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hAB, 0};
    vecs[4]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'h55, 0};
    vecs[5]  = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 8'h88, 0};
    vecs[6]  = '{1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h33, 0};
    vecs[7]  = '{1'b0, 1'b1, 8'h26, 8'h5A, 1'b0, 8'h00, 0};   // write hit
    vecs[8]  = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b1, 8'h5A, 0};
    vecs[9]  = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 8'hBB, 0};
    vecs[10] = '{1'b1, 1'b1, 8'h24, 8'h77, 1'b0, 8'h00, 0};   // read+write acts as write
    vecs[11] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 8'h77, 0};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 0};

    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #4;
    check("reset_busywait",  {31'b0, bus.busywait},  32'h0);
    check("reset_readdata",  {24'b0, bus.readdata},  32'h0);
    check("reset_mem_read",  {31'b0, bus.mem_read},  32'h0);
    check("reset_mem_write", {31'b0, bus.mem_write}, 32'h0);
    @(posedge clock); #1;

    // First miss: detect cycle, then registered mem_read with block address 0.
    bus.read = 1'b1; bus.address = 8'h00;
    #4;
    check("miss0_busywait", {31'b0, bus.busywait}, 32'h1);
    check("miss0_detect_mem_read", {31'b0, bus.mem_read}, 32'h0);
    stall = 1;
    @(posedge clock); #5;
    check("miss0_mem_read", {31'b0, bus.mem_read}, 32'h1);
    check("miss0_mem_write", {31'b0, bus.mem_write}, 32'h0);
    check("miss0_mem_address", {26'b0, bus.mem_address}, 32'h00);
    while (bus.busywait && stall < BUDGET) begin
      stall++;
      @(posedge clock); #5;
    end
    check("miss0_done", {31'b0, bus.busywait}, 32'h0);
    check("miss0_readdata", {24'b0, bus.readdata}, 32'h11);
    check("miss0_stall", stall, 5);
    @(posedge clock); #1;
    bus.read = 1'b0;

    access(1'b1, 1'b0, 8'h03, 8'h00, rdata, stall);
    check("hit03_readdata", {24'b0, rdata}, 32'h44);
    check("hit03_stall", stall, 0);
`ifdef DATA_CACHE_STATS_EN
    check("stats_hit_count", {16'b0, hit_count}, 32'd2);
    check("stats_miss_count", {16'b0, miss_count}, 32'd1);
`endif

    run_vecs(0, 6);

    // Dirty conflict on line 1: write-back of tag 0 block, then fetch of block 9.
    access(1'b1, 1'b0, 8'h25, 8'h00, rdata, stall);
    check("dirty_stall", stall, 8);
    check("dirty_readdata", {24'b0, rdata}, 32'hBB);
    check("dirty_wb_addr", {26'b0, wb_addr}, 32'h01);
    check("dirty_wb_data", wb_data, 32'h8877AB55);
    check("dirty_fill_addr", {26'b0, rd_addr}, 32'h09);
    check("dirty_wb_before_fill", {31'b0, wb_ev >= 0 && wb_ev < rd_ev}, 32'h1);

    tr0 = traffic;
    run_vecs(7, 12);
    check("hits_no_mem_traffic", traffic - tr0, 0);

    // Reset while the fetch for 0x40 is outstanding.
    bus.read = 1'b1; bus.address = 8'h40;
    @(posedge clock); #5;
    check("rst_mid_mem_read_before", {31'b0, bus.mem_read}, 32'h1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; bus.read = 1'b0;
    #4;
    check("rst_mid_mem_read", {31'b0, bus.mem_read}, 32'h0);
    check("rst_mid_busywait", {31'b0, bus.busywait}, 32'h0);
    check("rst_mid_readdata", {24'b0, bus.readdata}, 32'h0);
    @(posedge clock); #1;
    access(1'b1, 1'b0, 8'h00, 8'h00, rdata, stall);
    check("rst_invalidated_stall", stall, 5);
    check("rst_invalidated_readdata", {24'b0, rdata}, 32'h11);
    access(1'b1, 1'b0, 8'h40, 8'h00, rdata, stall);
    check("rst_retry_stall", stall, 5);
    check("rst_retry_readdata", {24'b0, rdata}, 32'hC0);

    check("mem_rd_wr_exclusive", {31'b0, overlap}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the 8-bit single-cycle `cpu` and the block-organised `data_memory`. It holds 8 blocks of 4 bytes and serves CPU byte reads and writes. Hits complete with no stall. Misses stall the CPU through `busywait` while a dirty victim is written back and the missing block is fetched as one 32-bit memory word.

## Interface
Parameters (none).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock, one reset.
- `read` in 1: CPU byte read request.
- `write` in 1: CPU byte write request.
- `address` in 8: byte address. Tag = [7:5], index = [4:2], offset = [1:0].
- `writedata` in 8: CPU store data.
- `readdata` out 8: CPU load data.
- `busywait` out 1: stall to CPU.
- `mem_read` out 1: block read request to memory.
- `mem_write` out 1: block write request to memory.
- `mem_address` out 6: block address, {tag,index}.
- `mem_writedata` out 32: victim block data; byte 0 in [7:0].
- `mem_readdata` in 32: fetched block data; byte 0 in [7:0].
- `mem_busywait` in 1: high while memory is completing a request.

## Operation
- Per line: `valid`, `dirty`, 3-bit `tag`, 32-bit data.
- `hit` = valid[index] && tag[index]==address[7:5]. Evaluated combinationally.
- Read hit: `readdata` = selected byte of the line, combinationally, in the same cycle. No state change.
- Write hit: the byte at the offset is written and `dirty` is set on the next rising edge.
- `readdata` holds its last value when no read hit is present. It is 8'h00 after reset.
- FSM states: IDLE, WRITE_BACK, MEM_READ, UPDATE.
  - IDLE: on (read|write) && !hit, go to WRITE_BACK if the line is valid and dirty, otherwise go to MEM_READ.
  - WRITE_BACK: `mem_write`=1, `mem_address`={old tag,index}, `mem_writedata`=line data. Go to MEM_READ on the first edge where `mem_busywait`=0.
  - MEM_READ: `mem_read`=1, `mem_address`=address[7:2]. Go to UPDATE on the first edge where `mem_busywait`=0.
  - UPDATE: load `mem_readdata`, tag=address[7:5], valid=1, dirty=0, then go to IDLE. The retried access then hits.
- `busywait` = ((read|write) && !hit) || state!=IDLE.
- Request lines are level-held by the CPU until `busywait` falls. The cache does not latch the address.
- read && write both high: treated as a write.
- Reset, including mid-miss: state to IDLE, all valid=0, dirty=0, mem_read=0, mem_write=0, busywait=0 (no request), readdata=8'h00. The memory request is abandoned.

## Timing
- Hit: 0 stall cycles. A write hit commits at the edge that ends the CPU cycle.
- Clean miss: 1 (detect) + N (MEM_READ, until `mem_busywait` low) + 1 (UPDATE) cycles. Then the hit is served.
- Dirty miss: adds the WRITE_BACK occupancy before MEM_READ.
- `mem_read` and `mem_write` are never high together. They are registered-state decodes and glitch-free.
- `mem_address` and `mem_writedata` are stable for the whole request.

## Configuration
- `DATA_CACHE_STATS_EN` defined: adds outputs `hit_count` and `miss_count`, each 16 bits and wrapping.
  - A hit increments `hit_count` when a request completes in IDLE with busywait low.
  - A miss increments `miss_count` on the IDLE→miss transition.
  - Both are cleared by reset.
- Undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package `data_cache_pkg` holds:
  - state enum (IDLE, WRITE_BACK, MEM_READ, UPDATE);
  - TAG_W=3, INDEX_W=3, OFFSET_W=2, LINES=8, BLOCK_W=32.
- One sub-module, `data_cache_ctrl`: the FSM and memory-handshake logic. The tag/data arrays stay in the top.

## Test plan
- Reset, then read 0x00: busywait high, mem_read with mem_address=6'h00. Memory returns 32'h44332211. readdata=8'h11 on retry; a read of 0x03 hits with 8'h44 and no stall.
- Write 0xAB to 0x05 (clean miss): block fetched, then byte 1 of line 1 = 8'hAB, dirty set. Read 0x05 hits with 8'hAB.
- Dirty conflict: after the previous case, read 0x25 (tag 1, index 1). mem_write with mem_address=6'h01 and data containing AB at [15:8] happens first, then mem_read with mem_address=6'h09.
- Write hit on a valid line: no busywait, no memory traffic, value readable next cycle.
- Reset asserted during MEM_READ: next cycle state IDLE, mem_read=0, and a read of the same address misses again.
- With `DATA_CACHE_STATS_EN`: the sequence miss, hit, hit gives miss_count=1 and hit_count=2.
